// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: byte width, bit timing
// default and the arbiter FSM state encoding.
package uart_tx_arbiter_pkg;

  localparam int BYTE_W         = 8;
  localparam int CYCLES_PER_BIT = 10416;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Round-robin selector: returns the first asserted request at or after ptr,
// wrapping around, as a one-hot grant vector.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  always_comb begin
    logic             found;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      // Extra bit on sum lets ptr+k exceed N before the wrap back into range.
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(N)) begin
        sum = sum - (PTR_W + 1)'(N);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Multiplexes byte streams from several requesters onto one UART byte
// transmitter, locking the grant to one requester for a whole message.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]         tx_data,
  output logic                      tx_start,
  input  logic                      tx_busy,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      tx_err
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(ACK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    last_owner_q, last_owner_d;
  logic                last_flag_q, last_flag_d;
  logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_start_q, tx_start_d;
  logic                tx_err_q, tx_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [IDX_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]  win_onehot;
  logic [IDX_W-1:0]    win_idx;
  logic                owner_valid;
  logic                owner_last;
  logic [BYTE_W-1:0]   owner_byte;
  logic                byte_done;

  assign rr_ptr = (last_owner_q == LAST_IDX) ? '0 : last_owner_q + 1'b1;

  rr_arbiter #(
    .N     (NUM_REQ),
    .PTR_W (IDX_W)
  ) u_rr (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (win_onehot)
  );

  always_comb begin
    win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_onehot[k]) win_idx = IDX_W'(k);
    end
  end

  // Only the owner's lane is ever looked at, so other requesters cannot disturb a message.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_byte  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IDX_W'(k)) begin
        owner_valid = req_valid[k];
        owner_last  = req_last[k];
        owner_byte  = req_data[k*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_SEND) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (owner_q == IDX_W'(k)) req_ready[k] = req_valid[k] & ~tx_busy;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    last_flag_d  = last_flag_q;
    tx_data_d    = tx_data_q;
    tx_start_d   = 1'b0;
    tx_err_d     = 1'b0;
    cnt_d        = cnt_q;
    byte_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = win_onehot;
          owner_d = win_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (owner_valid && !tx_busy) begin
          tx_data_d   = owner_byte;
          tx_start_d  = 1'b1;
          last_flag_d = owner_last;
          cnt_d       = '0;
          state_d     = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q >= CNT_LIMIT) begin
          // Transmitter never acknowledged: flag it and move on rather than hang.
          tx_err_d  = 1'b1;
          byte_done = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) byte_done = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (byte_done) begin
      if (last_flag_q) begin
        state_d      = ST_IDLE;
        grant_d      = '0;
        last_owner_d = owner_q;
      end else begin
        state_d = ST_SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      last_flag_q  <= 1'b0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_err_q     <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      last_flag_q  <= last_flag_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      tx_err_q     <= tx_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign grant    = grant_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign tx_err   = tx_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a round-robin message-order model
// feeds an expected-byte queue that a monitor checks on every tx_start.
module tb_uart_tx_arbiter;

  localparam int NR       = 4;
  localparam int TO       = 16;
  localparam int BUSY_LEN = 10;
  localparam int DEPTH    = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [8*NR-1:0] req_data = '0;
  logic [NR-1:0]   req_last = '0;
  logic [NR-1:0]   req_ready;
  logic [7:0]      tx_data;
  logic            tx_start;
  logic            tx_busy = 1'b0;
  logic [NR-1:0]   grant;
  logic            tx_err;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .ACK_TIMEOUT(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .tx_busy   (tx_busy),
    .grant     (grant),
    .tx_err    (tx_err)
  );

  // Per-requester byte sources
  logic [7:0]  rq_data [NR][DEPTH];
  logic        rq_last [NR][DEPTH];
  int          rq_head [NR];
  int          rq_tail [NR];
  int          gap_cnt [NR];
  bit          gap_arm [NR];
  logic [NR-1:0] hs_pending = '0;

  // Next round of messages (one per requester at most) and the reference state
  int          rnd_len  [NR];
  logic [7:0]  rnd_byte [NR][8];
  int          model_last = NR - 1;
  logic [11:0] exp_q [$];

  bit busy_en = 1'b1;
  int busy_cnt = 0;
  int since_start = 1000;
  int err_seen = 0;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  // Reference: each pending message goes out whole, requesters taken in
  // circular order starting just after the one served last.
  task automatic issue_round();
    int ptr;
    int pick;
    int r;
    bit served [NR];
    for (int i = 0; i < NR; i++) served[i] = 1'b0;
    ptr = (model_last + 1) % NR;
    for (int n = 0; n < NR; n++) begin
      pick = -1;
      for (int k = 0; k < NR; k++) begin
        r = (ptr + k) % NR;
        if (pick < 0 && rnd_len[r] > 0 && !served[r]) pick = r;
      end
      if (pick >= 0) begin
        for (int j = 0; j < rnd_len[pick]; j++) begin
          exp_q.push_back({4'(pick), rnd_byte[pick][j]});
          rq_data[pick][rq_tail[pick]] = rnd_byte[pick][j];
          rq_last[pick][rq_tail[pick]] = (j == rnd_len[pick] - 1);
          rq_tail[pick]++;
        end
        served[pick] = 1'b1;
        model_last   = pick;
        ptr          = (pick + 1) % NR;
      end
    end
    $display("round issued: %0d bytes expected, last owner %0d", exp_q.size(), model_last);
  endtask

  task automatic clear_round();
    for (int i = 0; i < NR; i++) begin
      rnd_len[i] = 0;
      for (int j = 0; j < 8; j++) rnd_byte[i][j] = 8'($urandom);
    end
  endtask

  function automatic bit sources_empty();
    bit e;
    e = 1'b1;
    for (int i = 0; i < NR; i++) if (rq_head[i] != rq_tail[i]) e = 1'b0;
    return e;
  endfunction

  task automatic drain(input string name);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 3000) begin
      tick();
      n++;
      done = (exp_q.size() == 0) && (grant == '0) && !tx_busy && sources_empty();
    end
    check(name, 32'(done), 32'd1);
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
  endtask

  // Monitor: compares every transmitted byte and owner against the scoreboard
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (since_start < 1000) since_start++;
      if (tx_start) begin
        since_start = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(tx_data), 32'(e[7:0]));
          check("tx_owner", 32'(grant), 32'(1) << e[11:8]);
          $display("tx byte %02h from grant %b", tx_data, grant);
        end
      end
      if (tx_err) begin
        err_seen++;
        if (busy_en) check("tx_err_spurious", 32'd1, 32'd0);
        else check("tx_err_delay", 32'(since_start), 32'(TO));
      end
      check("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
      if (tx_busy) check("ready_while_busy", 32'(req_ready), 32'd0);
    end
  end

  // Requester sources and a transmitter that stays busy BUSY_LEN cycles per byte
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (gap_cnt[i] > 0) gap_cnt[i]--;
      for (int i = 0; i < NR; i++) begin
        if (hs_pending[i]) begin
          rq_head[i]++;
          if (gap_arm[i]) begin
            gap_arm[i] = 1'b0;
            gap_cnt[i] = 20;
          end
        end
      end
      if (tx_start && busy_en) busy_cnt = BUSY_LEN;
      if (busy_cnt > 0) begin
        tx_busy = 1'b1;
        busy_cnt--;
      end else begin
        tx_busy = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (rq_head[i] < rq_tail[i] && gap_cnt[i] == 0) begin
          req_valid[i]       = 1'b1;
          req_data[i*8 +: 8] = rq_data[i][rq_head[i]];
          req_last[i]        = rq_last[i][rq_head[i]];
        end else begin
          req_valid[i]       = 1'b0;
          req_data[i*8 +: 8] = 8'($urandom);
          req_last[i]        = 1'($urandom);
        end
      end
      #1;
      hs_pending = reset ? '0 : (req_valid & req_ready);
    end
  end

  initial begin
    int n;
    int e0;
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
      gap_cnt[i] = 0;
      gap_arm[i] = 1'b0;
    end
    clear_round();

    reset = 1'b1;
    repeat (3) tick();
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_tx_start", 32'(tx_start), 32'd0);
    check("reset_tx_data", 32'(tx_data), 32'd0);
    check("reset_tx_err", 32'(tx_err), 32'd0);
    reset = 1'b0;
    tick();

    // Single requester, fixed message, start latency
    clear_round();
    rnd_len[0] = 3;
    rnd_byte[0][0] = 8'h57;
    rnd_byte[0][1] = 8'h65;
    rnd_byte[0][2] = 8'h6C;
    issue_round();
    n = 0;
    do begin
      tick();
      n++;
    end while (!tx_start && n < 20);
    check("start_latency_ticks", 32'(n), 32'd3);
    drain("single_drain");
    check("idle_grant", 32'(grant), 32'd0);

    // Two simultaneous requesters, then round-robin wrap to 3 before 0
    clear_round();
    rnd_len[1] = 2;
    rnd_len[2] = 2;
    issue_round();
    drain("pair12_drain");
    clear_round();
    rnd_len[0] = 2;
    rnd_len[3] = 2;
    issue_round();
    drain("pair03_drain");

    // Reset while the transmitter is framing a byte
    clear_round();
    rnd_len[1] = 3;
    rnd_byte[1][0] = 8'hA5;
    issue_round();
    n = 0;
    while (!tx_busy && n < 50) begin
      tick();
      n++;
    end
    check("busy_seen", 32'(tx_busy), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("midreset_grant", 32'(grant), 32'd0);
    check("midreset_ready", 32'(req_ready), 32'd0);
    check("midreset_tx_start", 32'(tx_start), 32'd0);
    check("midreset_tx_data", 32'(tx_data), 32'd0);
    check("midreset_tx_err", 32'(tx_err), 32'd0);
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    hs_pending = '0;
    model_last = NR - 1;
    tick();
    reset = 1'b0;
    clear_round();
    rnd_len[3] = 2;
    rnd_len[0] = 2;
    issue_round();
    drain("after_reset_drain");

    // Owner stalls mid-message while requester 1 waits
    clear_round();
    rnd_len[0] = 2;
    rnd_len[1] = 1;
    gap_arm[0] = 1'b1;
    issue_round();
    n = 0;
    while (rq_head[0] < 1 && n < 50) begin
      tick();
      n++;
    end
    check("owner_first_byte", 32'(rq_head[0]), 32'd1);
    for (int k = 0; k < 18; k++) begin
      tick();
      check("lock_grant", 32'(grant), 32'b0001);
    end
    drain("lock_drain");

    // Transmitter never acknowledges
    busy_en = 1'b0;
    e0 = err_seen;
    clear_round();
    rnd_len[2] = 2;
    issue_round();
    drain("timeout_drain");
    check("timeout_err_count", 32'(err_seen - e0), 32'd2);
    busy_en = 1'b1;

    // Random rounds
    for (int r = 0; r < 10; r++) begin
      clear_round();
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 1) == 1) rnd_len[i] = $urandom_range(1, 4);
      end
      rnd_len[$urandom_range(0, NR - 1)] = $urandom_range(1, 4);
      issue_round();
      drain("random_drain");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, clk cycles to wait for tx_busy rising after tx_start.
REQ-003 SHALL have port clk  input  1  clock, all logic on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-006 SHALL have port req_data  input  8*NUM_REQ  per-requester byte, requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_last  input  NUM_REQ  byte is final byte of the requester's message.
REQ-008 SHALL have port req_ready  output  NUM_REQ  byte accepted this cycle (valid&ready handshake).
REQ-009 SHALL have port tx_data  output  8  byte to the UART byte transmitter, registered.
REQ-010 SHALL have port tx_start  output  1  one-cycle start pulse to the transmitter, registered.
REQ-011 SHALL have port tx_busy  input  1  transmitter is framing a byte (start, 8 data LSB first, stop).
REQ-012 SHALL have port grant  output  NUM_REQ  one-hot current message owner, all-zero when idle.
REQ-013 SHALL have port tx_err  output  1  one-cycle pulse on ACK_TIMEOUT expiry.

Function
REQ-014 SHALL implement FSM states IDLE, SEND, WAIT_ACK, WAIT_DONE.
REQ-015 IDLE: if any req_valid set, SHALL select a winner round-robin, searching from (last_owner+1) mod NUM_REQ; next cycle grant = winner, state SEND.
REQ-016 IDLE with no req_valid: SHALL stay IDLE, grant = 0.
REQ-017 SEND: req_ready[owner] SHALL be asserted combinationally iff req_valid[owner] && !tx_busy; all other req_ready bits SHALL be 0 in every state.
REQ-018 On SEND handshake edge: tx_data <= req_data[owner], tx_start <= 1 for exactly one cycle, last_flag <= req_last[owner], state WAIT_ACK.
REQ-019 Latency: req_valid in IDLE at cycle N with transmitter idle SHALL yield tx_start high at cycle N+2.
REQ-020 WAIT_ACK: on tx_busy high, SHALL go WAIT_DONE; if tx_busy not seen within ACK_TIMEOUT cycles after tx_start, SHALL pulse tx_err and proceed as if byte complete.
REQ-021 WAIT_DONE: on tx_busy low, SHALL go SEND if last_flag = 0, else IDLE with last_owner <= owner and grant cleared.
REQ-022 Message lock: owner SHALL keep grant across bytes until its req_last byte completes, even if its req_valid drops; other requesters SHALL NOT be served meanwhile.
REQ-023 Simultaneous requests SHALL be served in round-robin order, one full message each.
REQ-024 Timeout counter SHALL saturate and clear on entry to WAIT_ACK.
REQ-025 Changes to req_data/req_last of non-owners SHALL have no effect.

Reset
REQ-026 On reset: state IDLE, grant 0, req_ready 0, tx_start 0, tx_data 8'h00, tx_err 0, last_owner NUM_REQ-1 (so requester 0 wins first), timeout counter 0.
REQ-027 Reset mid-message SHALL abandon the message without a further tx_start; requester data is not replayed.

Structure
REQ-028 Shared include uart_defs.vh SHALL hold FSM state encodings, byte width 8 and default cycles-per-bit constant 10416.
REQ-029 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, pointer; output one-hot winner), reused elsewhere.
REQ-030 No clock-domain crossings; single clk domain.

Verification
REQ-031 Single requester 0 sends 3 bytes 8'h57,8'h65,8'h6C (last on third), transmitter model busy 10 cycles -> three tx_start pulses in order, tx_start 2 cycles after first req_valid, grant returns to 0.
REQ-032 Requesters 1 and 2 both valid at cycle N, 2-byte messages each -> all bytes of requester 1 then requester 2; no interleaving.
REQ-033 After requester 2 served, requesters 0 and 3 valid -> requester 3 served first (round-robin).
REQ-034 Transmitter model never raises tx_busy -> tx_err pulses 16 cycles after tx_start, FSM advances, no hang.
REQ-035 Owner drops req_valid for 20 cycles mid-message while requester 1 valid -> grant unchanged, requester 1 waits until owner's last byte completes.
REQ-036 Reset asserted in WAIT_DONE -> next cycle all outputs at reset values, next grant goes to requester 0.
